jump_offset_sequencer: RTL and testbench

//  Multi-cycle controller for the jump-offset register and jump-target adder. Arbitrates

---
 rtl/jump_ctrl_pkg.sv | 22 ++
 rtl/jump_offset_sequencer.sv | 127 ++++++++++++
 tb/tb_jump_offset_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/jump_ctrl_pkg.sv
// Shared definitions for the jump-offset control path.
//   state_e : sequencer FSM states (fixed 2-bit encodings)
//   gnt_e   : which requester currently owns the sequence
//   CNT_W   : width of the settle counter (SETTLE_CYCLES range 0..15)
package jump_ctrl_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DEC  = 2'd1,
        GNT_TRAP = 2'd2
    } gnt_e;

endpackage

// File: rtl/jump_offset_sequencer.sv
// Multi-cycle controller for the jump-offset register and jump-target adder.
// Arbitrates offset writes between decoder and trap unit (trap has priority),
// pulses the offset register load enable, waits SETTLE_CYCLES for the target
// to settle, then commits it to the PC. Stalls fetch while busy.
//
// Ports:
//   CLK          in   clock, rising edge
//   Reset        in   asynchronous active-high reset
//   DecReq       in   decoder jump request (held until DecAck)
//   DecOffset    in   decoder offset
//   DecAck       out  one-cycle pulse: decoder jump committed
//   TrapReq      in   trap vectored-jump request (held until TrapAck)
//   TrapOffset   in   trap vector offset
//   TrapAck      out  one-cycle pulse: trap jump committed
//   Flush        in   aborts an uncommitted sequence (LOAD/SETTLE only)
//   OffsetChange out  load enable for the jump-offset register
//   OffsetData   out  registered offset captured at grant
//   PCJumpWrite  out  load jump target into PC
//   Stall        out  high while a sequence is in flight
module jump_offset_sequencer
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             DecReq,
    input  logic [WIDTH-1:0] DecOffset,
    output logic             DecAck,
    input  logic             TrapReq,
    input  logic [WIDTH-1:0] TrapOffset,
    output logic             TrapAck,
    input  logic             Flush,
    output logic             OffsetChange,
    output logic [WIDTH-1:0] OffsetData,
    output logic             PCJumpWrite,
    output logic             Stall
);

    // Counter preload on SETTLE entry; unused when SETTLE_CYCLES is 0.
    localparam logic [CNT_W-1:0] SETTLE_INIT =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    state_e             state_q, state_d;
    gnt_e               gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   offset_data_q, offset_data_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            gnt_q         <= GNT_NONE;
            cnt_q         <= '0;
            offset_data_q <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            offset_data_q <= offset_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        cnt_d         = cnt_q;
        offset_data_d = offset_data_q;

        case (state_q)
            ST_IDLE: begin
                if (!Flush) begin
                    if (TrapReq) begin
                        gnt_d         = GNT_TRAP;
                        offset_data_d = TrapOffset;
                        state_d       = ST_LOAD;
                    end else if (DecReq) begin
                        gnt_d         = GNT_DEC;
                        offset_data_d = DecOffset;
                        state_d       = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // Abort leaves the offset register write in place; only the
                // PC commit is suppressed.
                if (Flush) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                end else if (SETTLE_CYCLES > 0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_INIT;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_SETTLE: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                end else if (cnt_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                // Flush is deliberately ignored here: the commit always completes.
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // Moore outputs: decoded from registered state only.
    assign OffsetChange = (state_q == ST_LOAD);
    assign PCJumpWrite  = (state_q == ST_COMMIT);
    assign DecAck       = (state_q == ST_COMMIT) && (gnt_q == GNT_DEC);
    assign TrapAck      = (state_q == ST_COMMIT) && (gnt_q == GNT_TRAP);
    assign Stall        = (state_q != ST_IDLE);
    assign OffsetData   = offset_data_q;

endmodule

// File: tb/tb_jump_offset_sequencer.sv
module tb_jump_offset_sequencer;

    logic        clk;
    logic        rst;
    logic        dec_req, trap_req, flush;
    logic [31:0] dec_off, trap_off;

    // a: SETTLE_CYCLES=1, b: SETTLE_CYCLES=3, c: SETTLE_CYCLES=0
    logic        a_dack, a_tack, a_oc, a_pcj, a_stall;
    logic [31:0] a_od;
    logic        b_dack, b_tack, b_oc, b_pcj, b_stall;
    logic [31:0] b_od;
    logic        c_dack, c_tack, c_oc, c_pcj, c_stall;
    logic [31:0] c_od;

    int passed = 0;
    int total  = 0;

    jump_offset_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1)) dut_a (
        .CLK(clk), .Reset(rst),
        .DecReq(dec_req), .DecOffset(dec_off), .DecAck(a_dack),
        .TrapReq(trap_req), .TrapOffset(trap_off), .TrapAck(a_tack),
        .Flush(flush), .OffsetChange(a_oc), .OffsetData(a_od),
        .PCJumpWrite(a_pcj), .Stall(a_stall)
    );

    jump_offset_sequencer #(.WIDTH(32), .SETTLE_CYCLES(3)) dut_b (
        .CLK(clk), .Reset(rst),
        .DecReq(dec_req), .DecOffset(dec_off), .DecAck(b_dack),
        .TrapReq(trap_req), .TrapOffset(trap_off), .TrapAck(b_tack),
        .Flush(flush), .OffsetChange(b_oc), .OffsetData(b_od),
        .PCJumpWrite(b_pcj), .Stall(b_stall)
    );

    jump_offset_sequencer #(.WIDTH(32), .SETTLE_CYCLES(0)) dut_c (
        .CLK(clk), .Reset(rst),
        .DecReq(dec_req), .DecOffset(dec_off), .DecAck(c_dack),
        .TrapReq(trap_req), .TrapOffset(trap_off), .TrapAck(c_tack),
        .Flush(flush), .OffsetChange(c_oc), .OffsetData(c_od),
        .PCJumpWrite(c_pcj), .Stall(c_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock edge; inputs changed afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dec_req = 1'b0; trap_req = 1'b0; flush = 1'b0;
        dec_off = '0; trap_off = '0;
        step(); step();

        // Reset state
        check("rst_oc",    {31'd0, a_oc},    32'd0);
        check("rst_pcj",   {31'd0, a_pcj},   32'd0);
        check("rst_dack",  {31'd0, a_dack},  32'd0);
        check("rst_tack",  {31'd0, a_tack},  32'd0);
        check("rst_stall", {31'd0, a_stall}, 32'd0);
        check("rst_od",    a_od,             32'd0);
        rst = 1'b0;

        // Decoder jump, SETTLE_CYCLES=1
        dec_req = 1'b1; dec_off = 32'h0000_0040;
        step(); // cycle 1: LOAD
        check("dec_c1_oc",    {31'd0, a_oc},    32'd1);
        check("dec_c1_od",    a_od,             32'h40);
        check("dec_c1_stall", {31'd0, a_stall}, 32'd1);
        check("dec_c1_pcj",   {31'd0, a_pcj},   32'd0);
        step(); // cycle 2: SETTLE
        check("dec_c2_oc",    {31'd0, a_oc},    32'd0);
        check("dec_c2_pcj",   {31'd0, a_pcj},   32'd0);
        check("dec_c2_stall", {31'd0, a_stall}, 32'd1);
        step(); // cycle 3: COMMIT
        check("dec_c3_pcj",   {31'd0, a_pcj},   32'd1);
        check("dec_c3_dack",  {31'd0, a_dack},  32'd1);
        check("dec_c3_tack",  {31'd0, a_tack},  32'd0);
        check("dec_c3_stall", {31'd0, a_stall}, 32'd1);
        dec_req = 1'b0;
        step(); // IDLE
        check("dec_c4_stall", {31'd0, a_stall}, 32'd0);
        check("dec_c4_pcj",   {31'd0, a_pcj},   32'd0);
        check("dec_c4_dack",  {31'd0, a_dack},  32'd0);
        check("dec_c4_od",    a_od,             32'h40);

        // Collision: trap wins, decoder served 4 cycles later
        do_reset();
        dec_req = 1'b1; dec_off = 32'h0000_0040;
        trap_req = 1'b1; trap_off = 32'h0000_0180;
        step();
        check("col_load_od", a_od, 32'h180);
        check("col_load_oc", {31'd0, a_oc}, 32'd1);
        step();
        step(); // COMMIT of trap
        check("col_tack", {31'd0, a_tack}, 32'd1);
        check("col_dack_not", {31'd0, a_dack}, 32'd0);
        check("col_pcj1", {31'd0, a_pcj}, 32'd1);
        trap_req = 1'b0;
        step(); // IDLE, dec_req still high
        check("col_idle_stall", {31'd0, a_stall}, 32'd0);
        check("col_idle_tack",  {31'd0, a_tack},  32'd0);
        step(); // LOAD for decoder
        check("col_dec_oc", {31'd0, a_oc}, 32'd1);
        check("col_dec_od", a_od, 32'h40);
        step();
        check("col_dec_settle_pcj", {31'd0, a_pcj}, 32'd0);
        step(); // COMMIT of decoder (4 cycles after TrapAck)
        check("col_dack", {31'd0, a_dack}, 32'd1);
        check("col_tack_not", {31'd0, a_tack}, 32'd0);
        dec_req = 1'b0;
        step();
        check("col_end_stall", {31'd0, a_stall}, 32'd0);

        // Flush in second SETTLE cycle, SETTLE_CYCLES=3
        do_reset();
        dec_req = 1'b1; dec_off = 32'h0000_0055;
        step(); // LOAD
        check("fs_load_oc", {31'd0, b_oc}, 32'd1);
        step(); // SETTLE 1
        check("fs_s1_stall", {31'd0, b_stall}, 32'd1);
        step(); // SETTLE 2
        check("fs_s2_pcj", {31'd0, b_pcj}, 32'd0);
        flush = 1'b1;
        step(); // IDLE
        check("fs_idle_stall", {31'd0, b_stall}, 32'd0);
        check("fs_idle_pcj",   {31'd0, b_pcj},   32'd0);
        check("fs_idle_dack",  {31'd0, b_dack},  32'd0);
        check("fs_idle_od",    b_od,             32'h55);
        dec_req = 1'b0; flush = 1'b0;
        step();
        check("fs_after1_pcj",  {31'd0, b_pcj},  32'd0);
        check("fs_after1_dack", {31'd0, b_dack}, 32'd0);
        step();
        check("fs_after2_pcj",   {31'd0, b_pcj},   32'd0);
        check("fs_after2_stall", {31'd0, b_stall}, 32'd0);

        // Flush during COMMIT is ignored
        do_reset();
        dec_req = 1'b1; dec_off = 32'h0000_0077;
        step(); step(); step(); // COMMIT
        flush = 1'b1; dec_req = 1'b0;
        check("fc_pcj",  {31'd0, a_pcj},  32'd1);
        check("fc_dack", {31'd0, a_dack}, 32'd1);
        step(); // IDLE, single pulse
        check("fc_pcj_once",  {31'd0, a_pcj},  32'd0);
        check("fc_dack_once", {31'd0, a_dack}, 32'd0);

        // Flush in IDLE blocks grant until released
        dec_req = 1'b1; dec_off = 32'h0000_0099;
        step();
        check("fi_hold_oc",    {31'd0, a_oc},    32'd0);
        check("fi_hold_stall", {31'd0, a_stall}, 32'd0);
        check("fi_hold_od",    a_od,             32'h77);
        flush = 1'b0;
        step();
        check("fi_grant_oc", {31'd0, a_oc}, 32'd1);
        check("fi_grant_od", a_od,          32'h99);
        step(); step(); // COMMIT
        check("fi_dack", {31'd0, a_dack}, 32'd1);
        dec_req = 1'b0;
        step();

        // SETTLE_CYCLES=0
        do_reset();
        dec_req = 1'b1; dec_off = 32'h0000_0020;
        step();
        check("s0_oc",   {31'd0, c_oc},  32'd1);
        check("s0_pcj0", {31'd0, c_pcj}, 32'd0);
        check("s0_od",   c_od,           32'h20);
        step();
        check("s0_pcj",  {31'd0, c_pcj},  32'd1);
        check("s0_dack", {31'd0, c_dack}, 32'd1);
        check("s0_oc0",  {31'd0, c_oc},   32'd0);
        dec_req = 1'b0;
        step();
        check("s0_idle_stall", {31'd0, c_stall}, 32'd0);

        // Asynchronous reset mid-SETTLE
        do_reset();
        dec_req = 1'b1; dec_off = 32'h0000_0033;
        step(); step(); // SETTLE
        dec_req = 1'b0;
        check("ar_pre_stall", {31'd0, b_stall}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_stall", {31'd0, b_stall}, 32'd0);
        check("ar_oc",    {31'd0, b_oc},    32'd0);
        check("ar_pcj",   {31'd0, b_pcj},   32'd0);
        check("ar_dack",  {31'd0, b_dack},  32'd0);
        check("ar_od",    b_od,             32'd0);
        step();
        rst = 1'b0;
        step();
        check("ar_rel_stall", {31'd0, b_stall}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
